// File: rtl/qkd_key_sifter_pkg.sv
// Shared definitions for the QKD key sifter: FSM state encoding, key word
// geometry and statistics counter width.
package qkd_sift_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    JUDGE   = 3'd2,
    EMIT    = 3'd3,
    ABORT   = 3'd4
  } state_t;

  localparam int KEY_BYTES = 4;
  localparam int CNT_W     = 16;

endpackage

// File: rtl/qkd_key_sifter_sat_counter.sv
// Saturating event counter: sticks at all-ones instead of wrapping.
module qkd_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Count single-cycle events, holding at the maximum value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/qkd_key_sifter.sv
// QKD key sifter: keeps rounds where both parties read in the same cycle,
// packs matching bytes into 32-bit key words and aborts on excessive QBER.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for round_start
// COLLECT | read window open, waiting for the first valid strobe
// JUDGE   | one cycle: compare captured bytes, update block statistics
// EMIT    | key word presented, waiting for key_ready
// ABORT   | error rate exceeded; sifter frozen until reset
module qkd_key_sifter
  import qkd_sift_pkg::*;
#(
  parameter int WINDOW     = 4,
  parameter int QBER_BLOCK = 16,
  parameter int QBER_MAX   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             round_start,
  input  logic             valid_A,
  input  logic             valid_B,
  input  logic [7:0]       out_A,
  input  logic [7:0]       out_B,
  output logic             key_valid,
  input  logic             key_ready,
  output logic [31:0]      key_data,
  output logic [CNT_W-1:0] sifted_count,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] drop_count,
  output logic             qber_alarm
);

  state_t      state;
  logic [3:0]  wcnt;
  logic [7:0]  cap_a;
  logic [7:0]  cap_b;
  logic [23:0] acc;
  logic [2:0]  byte_idx;
  logic [7:0]  blk_cnt;
  logic [7:0]  blk_err;

  logic        match;
  logic [2:0]  idx_next;
  logic [7:0]  blk_cnt_next;
  logic [7:0]  blk_err_next;
  logic        blk_done;
  logic        abort_now;
  logic        word_done;
  logic [31:0] word_next;

  logic        inc_sifted;
  logic        inc_err;
  logic        inc_drop;

  // JUDGE-cycle arithmetic; the three oldest bytes live in acc, the fourth
  // comes straight from the capture register when a word completes.
  assign match        = (cap_a == cap_b);
  assign idx_next     = match ? byte_idx + 3'd1 : byte_idx;
  assign blk_cnt_next = blk_cnt + 8'd1;
  assign blk_err_next = match ? blk_err : blk_err + 8'd1;
  assign blk_done     = (blk_cnt_next == 8'(QBER_BLOCK));
  assign abort_now    = blk_done && (blk_err_next > 8'(QBER_MAX));
  assign word_done    = (idx_next == 3'(KEY_BYTES));
  assign word_next    = {acc, cap_a};

  // Statistics increment strobes decoded from the current state and inputs.
  always_comb begin
    inc_sifted = 1'b0;
    inc_err    = 1'b0;
    inc_drop   = 1'b0;
    case (state)
      COLLECT: begin
        if (round_start) begin
          inc_drop = 1'b1;
        end else if (valid_A && valid_B) begin
          inc_drop = 1'b0;
        end else if (valid_A || valid_B) begin
          inc_drop = 1'b1;
        end else if (wcnt == 4'(WINDOW - 1)) begin
          inc_drop = 1'b1;
        end
      end
      JUDGE: begin
        inc_sifted = 1'b1;
        inc_err    = !match;
        inc_drop   = round_start;
      end
      EMIT: begin
        inc_drop = round_start;
      end
      default: begin
        inc_drop = 1'b0;
      end
    endcase
  end

  // Main sequencer with registered key and alarm outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      wcnt       <= '0;
      cap_a      <= '0;
      cap_b      <= '0;
      acc        <= '0;
      byte_idx   <= '0;
      blk_cnt    <= '0;
      blk_err    <= '0;
      key_valid  <= 1'b0;
      key_data   <= '0;
      qber_alarm <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (round_start) begin
            state <= COLLECT;
            wcnt  <= '0;
          end
        end
        COLLECT: begin
          // A new pair supersedes the open round, so it restarts the window.
          if (round_start) begin
            wcnt <= '0;
          end else if (valid_A && valid_B) begin
            cap_a <= out_A;
            cap_b <= out_B;
            state <= JUDGE;
          end else if (valid_A || valid_B) begin
            state <= IDLE;
          end else if (wcnt == 4'(WINDOW - 1)) begin
            state <= IDLE;
          end else begin
            wcnt <= wcnt + 4'd1;
          end
        end
        JUDGE: begin
          if (abort_now) begin
            state      <= ABORT;
            qber_alarm <= 1'b1;
            key_valid  <= 1'b0;
            key_data   <= '0;
            acc        <= '0;
            byte_idx   <= '0;
            blk_cnt    <= blk_cnt_next;
            blk_err    <= blk_err_next;
          end else begin
            blk_cnt <= blk_done ? 8'd0 : blk_cnt_next;
            blk_err <= blk_done ? 8'd0 : blk_err_next;
            if (word_done) begin
              key_data  <= word_next;
              key_valid <= 1'b1;
              acc       <= '0;
              byte_idx  <= '0;
              state     <= EMIT;
            end else begin
              if (match) begin
                acc <= word_next[23:0];
              end
              byte_idx <= idx_next;
              state    <= IDLE;
            end
          end
        end
        EMIT: begin
          if (key_ready) begin
            key_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        ABORT: begin
          qber_alarm <= 1'b1;
          key_valid  <= 1'b0;
          key_data   <= '0;
          acc        <= '0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  qkd_sat_counter #(.WIDTH(CNT_W)) u_sifted_cnt (
    .clk   (clk),
    .rst   (reset),
    .clear (1'b0),
    .inc   (inc_sifted),
    .count (sifted_count)
  );

  qkd_sat_counter #(.WIDTH(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst   (reset),
    .clear (1'b0),
    .inc   (inc_err),
    .count (err_count)
  );

  qkd_sat_counter #(.WIDTH(CNT_W)) u_drop_cnt (
    .clk   (clk),
    .rst   (reset),
    .clear (1'b0),
    .inc   (inc_drop),
    .count (drop_count)
  );

endmodule

// File: tb/tb_qkd_key_sifter.sv
// Self-checking bench for qkd_key_sifter: directed scenarios plus randomized
// rounds checked against a round-level reference model.
module tb_qkd_key_sifter;

  localparam int WINDOW     = 4;
  localparam int QBER_BLOCK = 16;
  localparam int QBER_MAX   = 2;
  localparam int KEY_BYTES  = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        round_start;
  logic        valid_A;
  logic        valid_B;
  logic [7:0]  out_A;
  logic [7:0]  out_B;
  logic        key_valid;
  logic        key_ready;
  logic [31:0] key_data;
  logic [15:0] sifted_count;
  logic [15:0] err_count;
  logic [15:0] drop_count;
  logic        qber_alarm;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int          m_sifted;
  int          m_err;
  int          m_drop;
  int          m_blk;
  int          m_blk_err;
  bit          m_alarm;
  bit          m_pending;
  logic [31:0] m_key;
  logic [7:0]  m_bytes[$];

  qkd_key_sifter #(
    .WINDOW     (WINDOW),
    .QBER_BLOCK (QBER_BLOCK),
    .QBER_MAX   (QBER_MAX)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .round_start  (round_start),
    .valid_A      (valid_A),
    .valid_B      (valid_B),
    .out_A        (out_A),
    .out_B        (out_B),
    .key_valid    (key_valid),
    .key_ready    (key_ready),
    .key_data     (key_data),
    .sifted_count (sifted_count),
    .err_count    (err_count),
    .drop_count   (drop_count),
    .qber_alarm   (qber_alarm)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  function automatic void model_reset();
    m_sifted  = 0;
    m_err     = 0;
    m_drop    = 0;
    m_blk     = 0;
    m_blk_err = 0;
    m_alarm   = 1'b0;
    m_pending = 1'b0;
    m_key     = 32'h0;
    m_bytes.delete();
  endfunction

  // One finished round: kept rounds are judged, everything else is a drop.
  function automatic void model_round(input bit kept, input logic [7:0] a, input logic [7:0] b);
    if (m_alarm) return;
    if (!kept) begin
      m_drop = sat_inc(m_drop);
      return;
    end
    m_sifted = sat_inc(m_sifted);
    m_blk++;
    if (a == b) begin
      m_bytes.push_back(a);
    end else begin
      m_err = sat_inc(m_err);
      m_blk_err++;
    end
    if (m_blk == QBER_BLOCK) begin
      if (m_blk_err > QBER_MAX) begin
        m_alarm   = 1'b1;
        m_pending = 1'b0;
        m_key     = 32'h0;
        m_bytes.delete();
        return;
      end
      m_blk     = 0;
      m_blk_err = 0;
    end
    if (m_bytes.size() == KEY_BYTES) begin
      m_key     = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
      m_pending = 1'b1;
      m_bytes.delete();
    end
  endfunction

  task automatic check_counters(input string tag);
    check_eq({tag, ".sifted"}, 32'(sifted_count), 32'(m_sifted));
    check_eq({tag, ".err"},    32'(err_count),    32'(m_err));
    check_eq({tag, ".drop"},   32'(drop_count),   32'(m_drop));
    check_eq({tag, ".alarm"},  32'(qber_alarm),   32'(m_alarm));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset       = 1'b1;
    round_start = 1'b0;
    valid_A     = 1'b0;
    valid_B     = 1'b0;
    key_ready   = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // Drive one round: round_start, optional restart inside the window, k idle
  // cycles, one cycle of valid strobes, then settle and drain any key word.
  task automatic run_round(input bit va, input bit vb, input logic [7:0] a, input logic [7:0] b,
                           input int k, input int restart_at, input bit judge_start,
                           input int rd, input int es);
    bit kept;
    bit alarm_before;
    @(negedge clk);
    round_start = 1'b1;
    @(negedge clk);
    round_start = 1'b0;
    if (restart_at >= 0) begin
      repeat (restart_at) @(negedge clk);
      round_start = 1'b1;
      @(negedge clk);
      round_start = 1'b0;
      if (!m_alarm) m_drop = sat_inc(m_drop);
    end
    repeat (k) @(negedge clk);
    valid_A = va;
    valid_B = vb;
    out_A   = a;
    out_B   = b;
    @(negedge clk);
    valid_A = 1'b0;
    valid_B = 1'b0;
    out_A   = 8'($urandom);
    out_B   = 8'($urandom);
    kept = va && vb && (k < WINDOW);
    alarm_before = m_alarm;
    model_round(kept, a, b);
    check_eq("kv_in_judge", 32'(key_valid), 32'h0);
    round_start = judge_start && kept;
    if (judge_start && kept && !alarm_before) m_drop = sat_inc(m_drop);
    @(negedge clk);
    round_start = 1'b0;
    check_eq("kv_after_judge", 32'(key_valid), 32'(m_pending));
    check_eq("alarm_after_judge", 32'(qber_alarm), 32'(m_alarm));
    check_eq("key_data", key_data, m_key);
    repeat (WINDOW) @(negedge clk);
    if (m_pending) begin
      for (int i = 0; i < rd; i++) begin
        round_start = (i < es);
        @(negedge clk);
        check_eq("kv_hold", 32'(key_valid), 32'h1);
        check_eq("key_hold", key_data, m_key);
      end
      if (es > 0) m_drop = (m_drop + es > 65535) ? 65535 : m_drop + es;
      round_start = 1'b0;
      key_ready   = 1'b1;
      @(negedge clk);
      key_ready = 1'b0;
      m_pending = 1'b0;
    end
    check_eq("kv_idle", 32'(key_valid), 32'(m_pending));
    check_counters("round");
  endtask

  task automatic random_batch(input int n, input int mis_den);
    for (int i = 0; i < n; i++) begin
      int          r;
      int          k;
      int          rs;
      int          rd;
      int          es;
      bit          va;
      bit          vb;
      bit          js;
      logic [7:0]  a;
      logic [7:0]  b;
      r  = $urandom_range(0, 9);
      va = (r != 1) && (r != 2);
      vb = (r != 0) && (r != 2);
      a  = 8'($urandom);
      b  = ($urandom_range(0, mis_den - 1) == 0) ? (a ^ 8'($urandom_range(1, 255))) : a;
      k  = $urandom_range(0, WINDOW);
      rs = ($urandom_range(0, 7) == 0) ? $urandom_range(0, WINDOW - 1) : -1;
      js = ($urandom_range(0, 7) == 0);
      rd = $urandom_range(0, 3);
      es = $urandom_range(0, rd);
      run_round(va, vb, a, b, k, rs, js, rd, es);
    end
  endtask

  initial begin
    reset       = 1'b1;
    round_start = 1'b0;
    valid_A     = 1'b0;
    valid_B     = 1'b0;
    key_ready   = 1'b0;
    out_A       = 8'h0;
    out_B       = 8'h0;
    model_reset();
    repeat (2) @(negedge clk);
    check_eq("rst.key_valid", 32'(key_valid), 32'h0);
    check_eq("rst.key_data", key_data, 32'h0);
    check_counters("rst");
    reset = 1'b0;

    // four matching rounds build 0x11223344
    run_round(1, 1, 8'h11, 8'h11, 0, -1, 0, 0, 0);
    run_round(1, 1, 8'h22, 8'h22, 1, -1, 0, 0, 0);
    run_round(1, 1, 8'h33, 8'h33, 2, -1, 0, 0, 0);
    run_round(1, 1, 8'h44, 8'h44, WINDOW - 1, -1, 0, 1, 0);
    check_eq("word1", key_data, 32'h11223344);
    check_eq("word1.sifted", 32'(sifted_count), 32'd4);

    // single-sided read, then a silent window
    do_reset();
    run_round(1, 0, 8'h55, 8'h55, 0, -1, 0, 0, 0);
    run_round(0, 0, 8'h00, 8'h00, 0, -1, 0, 0, 0);
    check_eq("drops.count", 32'(drop_count), 32'd2);
    check_eq("drops.sifted", 32'(sifted_count), 32'd0);
    run_round(1, 1, 8'h66, 8'h66, WINDOW, -1, 0, 0, 0);
    run_round(1, 1, 8'h77, 8'h77, 0, 1, 1, 0, 0);

    // first block tolerates one error; second block aborts on the word-completing judge
    do_reset();
    for (int i = 0; i < QBER_BLOCK; i++) begin
      logic [7:0] a;
      a = 8'(i * 7 + 1);
      run_round(1, 1, a, (i == 5) ? (a ^ 8'h5A) : a, 0, -1, 0, 0, 0);
    end
    check_eq("blk1.alarm", 32'(qber_alarm), 32'h0);
    for (int i = 0; i < QBER_BLOCK; i++) begin
      logic [7:0] a;
      a = 8'(i * 13 + 3);
      run_round(1, 1, a, (i == 0 || i == 4 || i == 8) ? (a ^ 8'hA5) : a, 0, -1, 0, 0, 0);
    end
    check_eq("abort.alarm", 32'(qber_alarm), 32'h1);
    check_eq("abort.key_data", key_data, 32'h0);
    run_round(1, 1, 8'h12, 8'h12, 0, -1, 0, 0, 0);
    run_round(1, 0, 8'h12, 8'h12, 0, -1, 0, 0, 0);
    check_eq("abort.sifted_frozen", 32'(sifted_count), 32'd32);

    // stalled consumer with round_start pulses during EMIT
    do_reset();
    run_round(1, 1, 8'hDE, 8'hDE, 0, -1, 0, 0, 0);
    run_round(1, 1, 8'hAD, 8'hAD, 0, -1, 0, 0, 0);
    run_round(1, 1, 8'hBE, 8'hBE, 0, -1, 0, 0, 0);
    run_round(1, 1, 8'hEF, 8'hEF, 0, -1, 0, 10, 2);
    check_eq("stall.drop", 32'(drop_count), 32'd2);
    check_eq("stall.word", key_data, 32'hDEADBEEF);

    // reset in the middle of a round with three bytes accumulated
    do_reset();
    run_round(1, 1, 8'h01, 8'h01, 0, -1, 0, 0, 0);
    run_round(1, 1, 8'h02, 8'h02, 0, -1, 0, 0, 0);
    run_round(1, 1, 8'h03, 8'h03, 0, -1, 0, 0, 0);
    @(negedge clk);
    round_start = 1'b1;
    @(negedge clk);
    round_start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #2;
    model_reset();
    check_eq("midrst.key_valid", 32'(key_valid), 32'h0);
    check_eq("midrst.key_data", key_data, 32'h0);
    check_counters("midrst");
    @(negedge clk);
    reset = 1'b0;
    run_round(1, 1, 8'hA1, 8'hA1, 0, -1, 0, 0, 0);
    run_round(1, 1, 8'hB2, 8'hB2, 0, -1, 0, 0, 0);
    run_round(1, 1, 8'hC3, 8'hC3, 0, -1, 0, 0, 0);
    run_round(1, 1, 8'hD4, 8'hD4, 0, -1, 0, 0, 0);
    check_eq("fresh.word", key_data, 32'hA1B2C3D4);

    // randomized rounds: low then high mismatch rate
    do_reset();
    random_batch(80, 20);
    do_reset();
    random_batch(60, 3);

    // drop counter saturation: each cycle of held round_start in COLLECT is a drop
    do_reset();
    @(negedge clk);
    round_start = 1'b1;
    repeat (65535) @(negedge clk);
    check_eq("sat.fffe", 32'(drop_count), 32'h0000FFFE);
    repeat (3) @(negedge clk);
    check_eq("sat.ffff", 32'(drop_count), 32'h0000FFFF);
    round_start = 1'b0;
    repeat (WINDOW + 2) @(negedge clk);
    check_eq("sat.nowrap", 32'(drop_count), 32'h0000FFFF);
    check_eq("sat.sifted", 32'(sifted_count), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
